mem_responder: RTL and testbench

- Data-memory responder for the multicycle CPU: the slave end of a request/acknowledge memory handshake, replacing the fixed-latency synchronous memory on the data path.
- Accepts word, halfword or byte reads and writes from the CPU control unit.
- Inserts a programmable number of wait states and flags misaligned or out-of-range accesses so the control unit can route to its exception path.

---
 rtl/mem_pkg.sv | 48 ++++
 rtl/mem_lane_sel.sv | 57 +++++
 rtl/mem_responder.sv | 195 +++++++++++++++++++
 tb/tb_mem_responder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the data-memory request/acknowledge handshake.
// Used by mem_responder and mem_lane_sel, and by the CPU control unit, which
// reuses the default wait-state count for its own memory-wait states.
//
// Contents:
//   DEPTH_LOG2_DEF   default log2 of storage depth in 32-bit words
//   WAIT_CYCLES_DEF  default number of wait states (legal 0..15)
//   size_e           access size encoding carried on the 'size' port
//   mem_state_e      2-bit responder FSM state encoding
//   size_fault       helper: alignment / reserved-size check
// ---------------------------------------------------------------------------
package mem_pkg;

  localparam int DEPTH_LOG2_DEF  = 8;
  localparam int WAIT_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_WAIT   = 2'b01,
    ST_ACCESS = 2'b10,
    ST_RESP   = 2'b11
  } mem_state_e;

  // True when the size code is reserved or the low address bits do not
  // match the natural alignment of the access size.
  function automatic logic size_fault(input logic [1:0] size,
                                      input logic [1:0] lane);
    logic f;
    f = 1'b0;
    case (size)
      SZ_BYTE: f = 1'b0;
      SZ_HALF: f = lane[0];
      SZ_WORD: f = (lane != 2'b00);
      default: f = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/mem_lane_sel.sv
// ---------------------------------------------------------------------------
// mem_lane_sel
// Combinational byte-lane steering for the data memory. Lanes are
// little-endian: lane 0 is bits 7:0 of the stored word.
//
// Ports:
//   old_word  in  32  current contents of the addressed word
//   wdata     in  32  write data, right-justified for byte/halfword
//   size      in  2   access size (size_e encoding)
//   lane      in  2   byte address bits [1:0]
//   merged    out 32  old_word with only the addressed lanes replaced
//   extracted out 32  addressed lane(s) of old_word, right-justified,
//                     zero-extended
// Alignment is assumed to have been checked by the caller; a halfword
// uses lane[1] only, a word ignores lane.
// ---------------------------------------------------------------------------
module mem_lane_sel
  import mem_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  output logic [31:0] merged,
  output logic [31:0] extracted
);

  logic [4:0] byte_bit;
  logic [4:0] half_bit;

  assign byte_bit = {lane, 3'b000};
  assign half_bit = {lane[1], 4'b0000};

  always_comb begin
    merged    = old_word;
    extracted = 32'h0;
    case (size)
      SZ_BYTE: begin
        merged[byte_bit +: 8] = wdata[7:0];
        extracted[7:0]        = old_word[byte_bit +: 8];
      end
      SZ_HALF: begin
        merged[half_bit +: 16] = wdata[15:0];
        extracted[15:0]        = old_word[half_bit +: 16];
      end
      SZ_WORD: begin
        merged    = wdata;
        extracted = old_word;
      end
      default: begin
        merged    = old_word;
        extracted = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
// Slave end of the CPU data-memory request/acknowledge handshake. Accepts
// byte/halfword/word reads and writes, inserts WAIT_CYCLES wait states,
// and rejects misaligned, out-of-range or reserved-size accesses with err.
//
// Parameters:
//   DEPTH_LOG2   log2 of storage depth in 32-bit words (<= 29)
//   WAIT_CYCLES  wait states between acceptance and array access (0..15)
//
// Ports:
//   clk    in  1   rising-edge clock
//   reset  in  1   asynchronous active-low reset
//   req    in  1   request valid, held until ack
//   we     in  1   1 = write, 0 = read
//   size   in  2   00 byte, 01 halfword, 10 word, 11 reserved
//   addr   in  32  byte address
//   wdata  in  32  write data, right-justified
//   ack    out 1   one-cycle completion pulse
//   rdata  out 32  read data, right-justified, zero-extended
//   err    out 1   access rejected, valid with ack
//   busy   out 1   high from acceptance until the ack cycle
//
// Latency from the accepting IDLE cycle to ack: WAIT_CYCLES + 2 cycles,
// or 1 cycle for a rejected access. The storage array has no reset.
// ---------------------------------------------------------------------------
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_LOG2  = DEPTH_LOG2_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  // The counter counts down to zero inclusive, so it starts one below the
  // number of wait states to spend exactly WAIT_CYCLES cycles in WAIT.
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam bit HAS_WAIT = (WAIT_CYCLES > 0);

  mem_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] mem_q [DEPTH];

  logic                  fault;
  logic                  out_of_range;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [31:0]           old_word;
  logic [31:0]           merged_word;
  logic [31:0]           read_word;
  logic                  mem_wr;

  // Request qualification uses the live inputs in the accepting cycle.
  assign out_of_range = |addr[31:DEPTH_LOG2+2];
  assign fault        = size_fault(size, addr[1:0]) | out_of_range;

  assign word_idx = addr_q[DEPTH_LOG2+1:2];
  assign old_word = mem_q[word_idx];
  assign mem_wr   = (state_q == ST_ACCESS) && we_q;

  mem_lane_sel u_lane_sel (
    .old_word  (old_word),
    .wdata     (wdata_q),
    .size      (size_q),
    .lane      (addr_q[1:0]),
    .merged    (merged_word),
    .extracted (read_word)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          we_d    = we;
          size_d  = size;
          addr_d  = addr;
          wdata_d = wdata;
          if (fault) begin
            // Rejected: respond next cycle, storage is never touched.
            state_d = ST_RESP;
            ack_d   = 1'b1;
            err_d   = 1'b1;
            rdata_d = 32'h0;
            busy_d  = 1'b0;
          end else if (!HAS_WAIT) begin
            state_d = ST_ACCESS;
            busy_d  = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
            busy_d  = 1'b1;
          end
        end
      end

      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_ACCESS: begin
        // ack/err/busy are registered, so they are set up here to appear
        // exactly in the RESP cycle.
        state_d = ST_RESP;
        ack_d   = 1'b1;
        busy_d  = 1'b0;
        rdata_d = we_q ? 32'h0 : read_word;
      end

      ST_RESP: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage: single-cycle read-modify-write of the addressed word. Reset
  // clears the FSM asynchronously, so a write cut off in WAIT never lands.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem_q[word_idx] <= merged_word;
    end
  end

  assign ack   = ack_q;
  assign err   = err_q;
  assign busy  = busy_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam int WAIT_SLOW = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_s, req_f;
  logic        we_i;
  logic [1:0]  size_i;
  logic [31:0] addr_i, wdata_i;
  logic        ack_s, err_s, busy_s, ack_f, err_f, busy_f;
  logic [31:0] rdata_s, rdata_f;

  int ntot  = 0;
  int npass = 0;
  int nfail = 0;

  // Byte-addressed reference memories (1 KiB each), one per instance.
  logic [7:0] mm_s [1024];
  logic [7:0] mm_f [1024];

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(WAIT_SLOW)) u_slow (
    .clk(clk), .reset(rst_n), .req(req_s), .we(we_i), .size(size_i),
    .addr(addr_i), .wdata(wdata_i), .ack(ack_s), .rdata(rdata_s),
    .err(err_s), .busy(busy_s)
  );

  mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) u_fast (
    .clk(clk), .reset(rst_n), .req(req_f), .we(we_i), .size(size_i),
    .addr(addr_i), .wdata(wdata_i), .ack(ack_f), .rdata(rdata_f),
    .err(err_f), .busy(busy_f)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit model_fault(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1 && (a % 2) != 0) return 1'b1;
    if (sz == 2'd2 && (a % 4) != 0) return 1'b1;
    if (a >= 32'd1024) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_read(input bit fast, input logic [1:0] sz, input logic [31:0] a);
    logic [31:0] v;
    int n;
    v = 32'h0;
    n = 1 << sz;
    for (int k = 0; k < n; k++)
      v = v | (32'(fast ? mm_f[a + k] : mm_s[a + k]) << (8 * k));
    return v;
  endfunction

  task automatic model_write(input bit fast, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int n;
    n = 1 << sz;
    for (int k = 0; k < n; k++) begin
      if (fast) mm_f[a + k] = wd[8*k +: 8];
      else      mm_s[a + k] = wd[8*k +: 8];
    end
  endtask

  // One handshake: present the request, wait for ack (bounded), drop req.
  task automatic xfer(input bit fast, input bit w, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] wd,
                      output bit got, output int lat, output logic e,
                      output logic [31:0] rd, output logic b1, output logic bk);
    @(negedge clk);
    we_i = w; size_i = sz; addr_i = a; wdata_i = wd;
    if (fast) req_f = 1'b1; else req_s = 1'b1;
    got = 1'b0; lat = 0; e = 1'b0; rd = 32'h0; b1 = 1'b0; bk = 1'b1;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(posedge clk); #1;
      if (i == 1) b1 = fast ? busy_f : busy_s;
      if (fast ? ack_f : ack_s) begin
        got = 1'b1;
        lat = i;
        e   = fast ? err_f : err_s;
        rd  = fast ? rdata_f : rdata_s;
        bk  = fast ? busy_f : busy_s;
      end
    end
    req_f = 1'b0; req_s = 1'b0;
  endtask

  task automatic op(input bit fast, input bit w, input logic [1:0] sz,
                    input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
    bit f, got;
    int lat, exp_lat;
    logic e, b1, bk;
    logic [31:0] exp_rd;
    f       = model_fault(sz, a);
    exp_rd  = (f || w) ? 32'h0 : model_read(fast, sz, a);
    exp_lat = f ? 1 : (fast ? 2 : WAIT_SLOW + 2);
    xfer(fast, w, sz, a, wd, got, lat, e, rd, b1, bk);
    chk("ack_seen", 32'(got), 32'd1);
    chk("latency", lat, exp_lat);
    chk("err", 32'(e), 32'(f));
    chk("rdata", rd, exp_rd);
    chk("busy_after_accept", 32'(b1), 32'(!f));
    chk("busy_at_ack", 32'(bk), 32'd0);
    @(posedge clk); #1;
    chk("ack_one_cycle", 32'(fast ? ack_f : ack_s), 32'd0);
    if (!f && w) model_write(fast, sz, a, wd);
  endtask

  initial begin
    logic [31:0] rd, prior, rd1, rd2;
    int ack_edge1, ack_edge2, nacks;
    logic [1:0] sz;
    logic [31:0] a;
    int r;

    rst_n = 1'b0; req_s = 1'b0; req_f = 1'b0;
    we_i = 1'b0; size_i = 2'd0; addr_i = 32'h0; wdata_i = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack_s", 32'(ack_s), 32'd0);
    chk("rst_err_s", 32'(err_s), 32'd0);
    chk("rst_busy_s", 32'(busy_s), 32'd0);
    chk("rst_rdata_s", rdata_s, 32'h0);
    chk("rst_ack_f", 32'(ack_f), 32'd0);
    chk("rst_busy_f", 32'(busy_f), 32'd0);
    chk("rst_rdata_f", rdata_f, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Give every word a known value in both instances.
    for (int w = 0; w < 256; w++) begin
      op(1'b0, 1'b1, 2'd2, 32'(w * 4), $urandom, rd);
      op(1'b1, 1'b1, 2'd2, 32'(w * 4), $urandom, rd);
    end

    // Word write then read.
    op(1'b0, 1'b1, 2'd2, 32'h10, 32'hDEADBEEF, rd);
    op(1'b0, 1'b0, 2'd2, 32'h10, 32'h0, rd);
    chk("t1_word_read", rd, 32'hDEADBEEF);

    // Byte merge.
    op(1'b0, 1'b1, 2'd0, 32'h12, 32'h0000005A, rd);
    op(1'b0, 1'b0, 2'd2, 32'h10, 32'h0, rd);
    chk("t2_merged_word", rd, 32'hDE5ABEEF);
    op(1'b0, 1'b0, 2'd0, 32'h13, 32'h0, rd);
    chk("t2_byte_read", rd, 32'h000000DE);

    // Misaligned accesses.
    op(1'b0, 1'b0, 2'd1, 32'h11, 32'h0, rd);
    chk("t3_misaligned_rdata", rd, 32'h0);
    prior = model_read(1'b0, 2'd2, 32'h20);
    op(1'b0, 1'b1, 2'd2, 32'h22, 32'hCAFEF00D, rd);
    op(1'b0, 1'b0, 2'd2, 32'h20, 32'h0, rd);
    chk("t3_untouched", rd, prior);

    // Range boundary.
    op(1'b0, 1'b0, 2'd2, 32'h400, 32'h0, rd);
    op(1'b0, 1'b0, 2'd2, 32'h3FC, 32'h0, rd);
    chk("t4_last_word", rd, model_read(1'b0, 2'd2, 32'h3FC));

    // Back-to-back reads on the zero-wait instance with req held.
    @(negedge clk);
    we_i = 1'b0; size_i = 2'd2; addr_i = 32'h40; req_f = 1'b1;
    ack_edge1 = 0; ack_edge2 = 0; nacks = 0; rd1 = 32'h0; rd2 = 32'h0;
    for (int i = 1; i <= 12 && nacks < 2; i++) begin
      @(posedge clk); #1;
      if (ack_f) begin
        nacks++;
        if (nacks == 1) begin ack_edge1 = i; rd1 = rdata_f; end
        else begin ack_edge2 = i; rd2 = rdata_f; req_f = 1'b0; end
      end
    end
    req_f = 1'b0;
    chk("t5_ack_count", nacks, 2);
    chk("t5_first_latency", ack_edge1, 2);
    chk("t5_ack_spacing", ack_edge2 - ack_edge1, 3);
    chk("t5_rdata1", rd1, model_read(1'b1, 2'd2, 32'h40));
    chk("t5_rdata2", rd2, model_read(1'b1, 2'd2, 32'h40));
    @(posedge clk); #1;
    chk("t5_no_third_ack", 32'(ack_f), 32'd0);

    // Reset asserted while the write is waiting.
    prior = model_read(1'b0, 2'd2, 32'h20);
    @(negedge clk);
    we_i = 1'b1; size_i = 2'd2; addr_i = 32'h20; wdata_i = 32'h12345678; req_s = 1'b1;
    @(posedge clk); #1;
    chk("t6_busy_in_wait", 32'(busy_s), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_busy_cleared", 32'(busy_s), 32'd0);
    chk("t6_ack_low", 32'(ack_s), 32'd0);
    req_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("t6_no_ack", 32'(ack_s), 32'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    op(1'b0, 1'b0, 2'd2, 32'h20, 32'h0, rd);
    chk("t6_old_value", rd, prior);

    // Randomized mix on both instances.
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 9);
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a = (r == 0) ? $urandom : 32'($urandom_range(0, 1023));
      if (r < 8 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
      op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz, a, $urandom, rd);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
